// File: rtl/cascade_timer.sv
// cascade_timer: chain of modulo stage counters (e.g. s/m/h) advanced by a one-cycle tick,
// with up/down run mode and per-stage editing. Optional auto-repeat: CASCADE_TIMER_AUTOREPEAT_EN.
module cascade_timer #(
  parameter int WIDTH    = 8,
  parameter int STAGES   = 3,
  parameter int RANGE_LO = 60,
  parameter int RANGE_HI = 24,
  parameter int SELW     = 2,
  parameter int REPEAT   = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      power,
  input  logic                      enable,
  input  logic                      tick,
  input  logic                      mode_down,
  input  logic                      clear,
  input  logic [SELW-1:0]           sel,
  input  logic                      add_time,
  input  logic                      sub_time,
  output logic [STAGES*WIDTH-1:0]   count,
  output logic [STAGES-1:0]         carry,
  output logic                      sig_end,
  output logic                      running
);

  localparam logic [STAGES*WIDTH-1:0] CHAIN_ONE = {{(STAGES*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]        ONE_W     = WIDTH'(1);

  logic                    halted;
  logic                    halted_d;
  logic                    add_q;
  logic                    sub_q;
  logic                    mode_q;
  logic [STAGES*WIDTH-1:0] count_d;
  logic [STAGES-1:0]       carry_d;
  logic                    end_d;
  logic                    add_edge;
  logic                    sub_edge;
  logic                    edit_up;
  logic                    edit_dn;
  logic                    rep_up;
  logic                    rep_dn;
  logic                    ripple;
  logic [WIDTH-1:0]        cur;

  function automatic logic [WIDTH-1:0] stage_max(input int i);
    return (i == STAGES-1) ? WIDTH'(RANGE_HI - 1) : WIDTH'(RANGE_LO - 1);
  endfunction

  assign add_edge = add_time & ~add_q;
  assign sub_edge = sub_time & ~sub_q;

`ifdef CASCADE_TIMER_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT + 1);

  logic [HW-1:0] hold_q;
  logic [HW-1:0] hold_d;
  logic          held_add;
  logic          held_sub;
  logic          holding;

  // A button counts as held only when it was already high last sample and is pressed alone.
  assign held_add = add_time & add_q & ~sub_time;
  assign held_sub = sub_time & sub_q & ~add_time;
  assign holding  = power & ~clear & ~enable & (held_add | held_sub);

  always_comb begin
    hold_d = '0;
    rep_up = 1'b0;
    rep_dn = 1'b0;
    if (holding) begin
      hold_d = hold_q;
      if (tick) begin
        if (hold_q == HW'(REPEAT)) begin
          rep_up = held_add;
          rep_dn = held_sub;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = ^REPEAT;
  assign rep_up        = 1'b0;
  assign rep_dn        = 1'b0;
`endif

  assign edit_up = (add_edge & ~sub_edge) | rep_up;
  assign edit_dn = (sub_edge & ~add_edge) | rep_dn;

  always_comb begin
    count_d  = count;
    carry_d  = '0;
    end_d    = 1'b0;
    halted_d = halted;
    ripple   = 1'b1;
    cur      = '0;

    // Tick gating below uses the registered flag, so a direction change only takes effect next tick.
    if (mode_down != mode_q) begin
      halted_d = 1'b0;
    end

    if (!power || clear) begin
      count_d  = '0;
      halted_d = 1'b0;
    end else if (enable) begin
      if (tick && !halted) begin
        if (!mode_down) begin
          for (int i = 0; i < STAGES; i++) begin
            cur = count[i*WIDTH +: WIDTH];
            if (ripple) begin
              if (cur == stage_max(i)) begin
                count_d[i*WIDTH +: WIDTH] = '0;
                carry_d[i]                = 1'b1;
              end else begin
                count_d[i*WIDTH +: WIDTH] = cur + ONE_W;
                ripple                    = 1'b0;
              end
            end
          end
          end_d = ripple;
        end else if (count == '0) begin
          halted_d = 1'b1;
        end else begin
          for (int i = 0; i < STAGES; i++) begin
            cur = count[i*WIDTH +: WIDTH];
            if (ripple) begin
              if (cur == '0) begin
                count_d[i*WIDTH +: WIDTH] = stage_max(i);
                carry_d[i]                = 1'b1;
              end else begin
                count_d[i*WIDTH +: WIDTH] = cur - ONE_W;
                ripple                    = 1'b0;
              end
            end
          end
          if (count == CHAIN_ONE) begin
            end_d    = 1'b1;
            halted_d = 1'b1;
          end
        end
      end
    end else begin
      // Out-of-range sel matches no stage, so the edit falls away.
      for (int i = 0; i < STAGES; i++) begin
        if (sel == SELW'(i)) begin
          cur = count[i*WIDTH +: WIDTH];
          if (edit_up) begin
            count_d[i*WIDTH +: WIDTH] = (cur == stage_max(i)) ? '0 : cur + ONE_W;
            halted_d                  = 1'b0;
          end else if (edit_dn) begin
            count_d[i*WIDTH +: WIDTH] = (cur == '0) ? stage_max(i) : cur - ONE_W;
            halted_d                  = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      carry   <= '0;
      sig_end <= 1'b0;
      halted  <= 1'b0;
      add_q   <= 1'b0;
      sub_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      count   <= count_d;
      carry   <= carry_d;
      sig_end <= end_d;
      halted  <= halted_d;
      add_q   <= add_time;
      sub_q   <= sub_time;
      mode_q  <= mode_down;
    end
  end

  assign running = power & enable & ~halted;

endmodule

// File: tb/tb_cascade_timer.sv
// Scoreboard bench for cascade_timer: a mixed-radix total-value model predicts each cycle,
// a monitor compares after every clock edge. Honors CASCADE_TIMER_AUTOREPEAT_EN.
module tb_cascade_timer;

  localparam int STAGES = 3;
  localparam int WIDTH  = 8;
  localparam int REPEAT = 8;
  localparam int MODV   = 60 * 60 * 24;

  logic                    clk;
  logic                    reset_n;
  logic                    power;
  logic                    enable;
  logic                    tick;
  logic                    mode_down;
  logic                    clear;
  logic [1:0]              sel;
  logic                    add_time;
  logic                    sub_time;
  logic [STAGES*WIDTH-1:0] count;
  logic [STAGES-1:0]       carry;
  logic                    sig_end;
  logic                    running;

  cascade_timer #(
    .WIDTH(WIDTH), .STAGES(STAGES), .RANGE_LO(60), .RANGE_HI(24), .SELW(2), .REPEAT(REPEAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .power(power), .enable(enable), .tick(tick),
    .mode_down(mode_down), .clear(clear), .sel(sel), .add_time(add_time),
    .sub_time(sub_time), .count(count), .carry(carry), .sig_end(sig_end), .running(running)
  );

  typedef struct {
    logic [STAGES*WIDTH-1:0] count;
    logic [STAGES-1:0]       carry;
    logic                    sig_end;
    logic                    running;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  int   m_d[STAGES];
  bit   m_halted;
  bit   m_prev_add;
  bit   m_prev_sub;
  bit   m_prev_mode;
  int   m_hold;
  logic rnd_md;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  function automatic int radix(input int i);
    return (i == STAGES-1) ? 24 : 60;
  endfunction

  function automatic int total();
    int t = 0;
    for (int i = STAGES-1; i >= 0; i--) t = t * radix(i) + m_d[i];
    return t;
  endfunction

  task automatic set_total(input int t);
    for (int i = 0; i < STAGES; i++) begin
      m_d[i] = t % radix(i);
      t      = t / radix(i);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < STAGES; i++) m_d[i] = 0;
    m_halted    = 0;
    m_prev_add  = 0;
    m_prev_sub  = 0;
    m_prev_mode = 0;
    m_hold      = 0;
  endtask

  task automatic model_step(output exp_t e);
    bit ae, se, h0, up, dn, all0, rep_a, rep_s, ha, hs;
    int tot;
    e.carry   = '0;
    e.sig_end = 1'b0;
    ae    = add_time && !m_prev_add;
    se    = sub_time && !m_prev_sub;
    h0    = m_halted;
    rep_a = 0;
    rep_s = 0;
    ha    = add_time && m_prev_add && !sub_time;
    hs    = sub_time && m_prev_sub && !add_time;
`ifdef CASCADE_TIMER_AUTOREPEAT_EN
    if (power && !clear && !enable && (ha || hs)) begin
      if (tick) begin
        if (m_hold == REPEAT) begin
          rep_a = ha;
          rep_s = hs;
        end else begin
          m_hold++;
        end
      end
    end else begin
      m_hold = 0;
    end
`endif
    if (mode_down != m_prev_mode) m_halted = 0;
    if (!power || clear) begin
      set_total(0);
      m_halted = 0;
    end else if (enable) begin
      if (tick && !h0) begin
        tot = total();
        if (!mode_down) begin
          set_total((tot + 1) % MODV);
          all0 = 1;
          for (int i = 0; i < STAGES; i++) begin
            all0 = all0 && (m_d[i] == 0);
            e.carry[i] = all0;
          end
          e.sig_end = (total() == 0);
        end else if (tot == 0) begin
          m_halted = 1;
        end else begin
          all0 = 1;
          for (int i = 0; i < STAGES; i++) begin
            all0 = all0 && (m_d[i] == 0);
            e.carry[i] = all0;
          end
          set_total(tot - 1);
          if (tot == 1) begin
            e.sig_end = 1'b1;
            m_halted  = 1;
          end
        end
      end
    end else begin
      up = (ae && !se) || rep_a;
      dn = (se && !ae) || rep_s;
      if (int'(sel) < STAGES && (up || dn)) begin
        m_d[sel] = (m_d[sel] + (up ? 1 : radix(sel) - 1)) % radix(sel);
        m_halted = 0;
      end
    end
    m_prev_add  = add_time;
    m_prev_sub  = sub_time;
    m_prev_mode = mode_down;
    for (int i = 0; i < STAGES; i++) e.count[i*WIDTH +: WIDTH] = WIDTH'(m_d[i]);
    e.running = power && enable && !m_halted;
  endtask

  // Called at a falling edge: drive inputs, predict the next rising edge, wait for the next falling edge.
  task automatic step(input logic p, input logic e, input logic t, input logic md,
                      input logic c, input logic [1:0] s, input logic a, input logic b);
    exp_t x;
    power = p; enable = e; tick = t; mode_down = md; clear = c; sel = s; add_time = a; sub_time = b;
    model_step(x);
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  task automatic async_reset();
    #1 reset_n = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_end", 32'(sig_end), 32'd0);
    chk("rst_running", 32'(running), 32'(power & enable));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("count", 32'(count), 32'(x.count));
        chk("carry", 32'(carry), 32'(x.carry));
        chk("sig_end", 32'(sig_end), 32'(x.sig_end));
        chk("running", 32'(running), 32'(x.running));
      end
    end
  end

  initial begin : stim
    reset_n = 1'b0; power = 0; enable = 0; tick = 0; mode_down = 0; clear = 0;
    sel = 0; add_time = 0; sub_time = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_count", 32'(count), 32'd0);
    chk("init_carry", 32'(carry), 32'd0);
    chk("init_end", 32'(sig_end), 32'd0);
    reset_n = 1'b1;

    // up-count wrap from 59/59/23
    for (int s = 0; s < STAGES; s++) begin
      step(1, 0, 0, 0, 0, 2'(s), 0, 1);
      step(1, 0, 0, 0, 0, 2'(s), 0, 0);
    end
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);

    // down-count to zero, halt, resume after direction toggle
    step(1, 0, 0, 1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 0, 0, 0);
    repeat (5) step(1, 1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);

    // borrow from 0/5/0
    step(1, 0, 0, 1, 1, 0, 0, 0);
    repeat (5) begin
      step(1, 0, 0, 1, 0, 1, 1, 0);
      step(1, 0, 0, 1, 0, 1, 0, 0);
    end
    step(1, 1, 1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0, 0, 0, 0);

    // edits: wrap without carry, simultaneous buttons, bad sel, edge in run mode
    step(1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    repeat (3) begin
      step(1, 0, 0, 0, 0, 2, 1, 0);
      step(1, 0, 0, 0, 0, 2, 0, 0);
    end
    step(1, 0, 0, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 3, 1, 0);
    step(1, 0, 0, 0, 0, 3, 0, 1);
    step(1, 0, 0, 0, 0, 3, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // priority: clear beats tick, power-off beats everything
    step(1, 1, 1, 0, 1, 0, 0, 0);
    repeat (3) step(1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // asynchronous reset with a nonzero count
    repeat (4) step(1, 1, 1, 0, 0, 0, 0, 0);
    power = 1; enable = 1; tick = 0;
    async_reset();

`ifdef CASCADE_TIMER_AUTOREPEAT_EN
    step(1, 0, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0);
    repeat (12) step(1, 0, 1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("autorepeat_stage0", 32'(count[WIDTH-1:0]), 32'd5);
`endif

    // randomized traffic against the model
    rnd_md = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(99) < 3) rnd_md = ~rnd_md;
      step($urandom_range(99) < 97, $urandom_range(99) < 60, $urandom_range(99) < 60, rnd_md,
           $urandom_range(199) == 0, 2'($urandom_range(3)),
           $urandom_range(99) < 40, $urandom_range(99) < 25);
    end

    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cascade_timer.md
# cascade_timer

Parametrised multi-stage timer that replaces the single-range timer with a cascade of modulo counters, e.g. seconds/minutes/hours. It has up/down counting, per-stage time editing, and per-stage carry pulses. It runs on one system clock. Counting is advanced by a one-cycle `tick` strobe from the prescaler rather than by a dedicated slow clock. It sits between the prescaler and the display/alarm logic of the clock design.

## Interface
- `WIDTH`, 8: bits per stage counter. Must hold max(RANGE_LO, RANGE_HI) - 1.
- `STAGES`, 3: number of cascaded stages. Must be at least 2.
- `RANGE_LO`, 60: modulus of stages 0..STAGES-2.
- `RANGE_HI`, 24: modulus of stage STAGES-1.
- `SELW`, 2: width of `sel`. Must be at least clog2(STAGES).
- `REPEAT`, 8: tick count before auto-repeat starts. Used only when the macro below is defined.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `power`  in  1  0 = powered off; all stages forced to 0.
- `enable`  in  1  1 = run mode; 0 = edit mode (counting paused).
- `tick`  in  1  one-`clk` count strobe.
- `mode_down`  in  1  0 = count up, 1 = count down.
- `clear`  in  1  synchronous clear of all stages.
- `sel`  in  SELW  stage selected for editing.
- `add_time`  in  1  level button; rising edge increments the selected stage.
- `sub_time`  in  1  level button; rising edge decrements the selected stage.
- `count`  out  STAGES*WIDTH  stage i occupies bits [i*WIDTH +: WIDTH].
- `carry`  out  STAGES  per-stage wrap/borrow pulse.
- `sig_end`  out  1  chain-end pulse.
- `running`  out  1  power & enable & ~halted.

## Operation
- All outputs are registered. Reset (`reset_n`=0) sets `count`, `carry` and `sig_end` to 0 and clears the `halted` flag. `running` then follows its inputs.
- Per-cycle priority: `reset_n` > `power`=0 > `clear` > run tick > edit.
- **Power off** (`power`=0): counts go to 0, `halted` is cleared, and `carry`/`sig_end` are held at 0. All buttons are ignored.
- **Clear**: counts go to 0 and `halted` is cleared.
- **Run, up** (`enable`=1, `mode_down`=0, `tick`=1):
  - Stage 0 increments.
  - Stage i increments only if every lower stage is at its range-1.
  - A stage at range-1 that receives an increment wraps to 0 and pulses `carry[i]`.
  - Wrap of the top stage pulses `sig_end`; the chain continues from all-zero.
- **Run, down** (`mode_down`=1):
  - Stage 0 decrements.
  - Stage i decrements only if all lower stages are 0.
  - A stage at 0 that is decremented wraps to range-1 and pulses `carry[i]`.
  - When a tick decrements the chain from all-zero-except-stage0=1 to all-zero, `sig_end` pulses and `halted` is set.
  - While halted, ticks are ignored and `running`=0. `halted` is cleared by `clear`, by power-off, by a `mode_down` change, or by any edit.
  - A tick arriving while the chain is already all-zero and not halted sets `halted` without wrapping and does not pulse `sig_end`.
- **Edit** (`power`=1, `enable`=0):
  - An edge on `add_time` or `sub_time` is a sampled 1 where the previous sample was 0.
  - An add edge increments stage `sel` modulo its range. A sub edge decrements it modulo its range.
  - Edits never propagate carries and never pulse `carry`/`sig_end`.
  - Simultaneous add and sub edges leave the count unchanged.
  - `sel` >= STAGES: the edit is ignored.
  - Edges occurring while `enable`=1 are discarded, not queued. The edge detectors keep sampling in every mode.
- `mode_down` may change at any time. The new direction applies from the next tick.

## Timing
- Count latency: `count` reflects a tick at the same `clk` rising edge where `tick`=1 is sampled.
- `carry` and `sig_end` are high for exactly the one cycle following that edge.
- Edit latency: the count changes at the first rising edge where `add_time`=1 is sampled after a 0 sample. Holding the button produces no further change unless auto-repeat is compiled in.
- Asserting `reset_n`=0 mid-cycle clears outputs immediately. Deassertion must be synchronous to `clk`.
- All inputs are synchronous to `clk`. Synchronisers and debouncing live upstream.

## Configuration
- Macro `CASCADE_TIMER_AUTOREPEAT_EN`.
- **Defined**:
  - In edit mode, holding `add_time` (or `sub_time`) alone without releasing it counts ticks.
  - After REPEAT ticks, the selected stage steps once per subsequent tick, in the same direction and on the same edge as the tick.
  - Releasing the button or leaving edit mode resets the hold counter.
- **Undefined**: only edges edit, and `REPEAT` is unused.

## Test plan
- **Up-count wrap.** Power on, enable=1, mode_down=0; load 59/59/23 via edits; then tick once. Expect count 0/0/0, carry=3'b111 for one cycle, and sig_end=1 for one cycle.
- **Down-count to zero.** Set 1/0/0 with mode_down=1 and tick once. Expect 0/0/0, sig_end pulse, and running=0. Five more ticks leave the count at 0/0/0 with no pulses. Toggling mode_down then lets counting resume.
- **Borrow.** Start at 0/5/0 counting down and tick. Expect 59/4/0 and carry[0]=1 only.
- **Edits.**
  - enable=0, sel=1: add edge on 59 gives 0 with stage 2 unchanged and no carry.
  - add and sub rising together: no change.
  - sel=3: ignored.
  - add edge while enable=1: ignored.
- **Priority and reset.**
  - clear asserted together with tick gives 0/0/0.
  - power=0 mid-run zeroes the count the next edge, and buttons are ignored.
  - reset_n low between edges zeroes outputs asynchronously.
- **Auto-repeat** (macro defined, REPEAT=8). Hold add_time for 12 ticks on stage 0 starting from 0. Expect 1 after the edge, then 5 after the 12th tick.
